// File: rtl/seg_pkg.sv
// Glyph table and scan-state encoding shared by the seven-segment bus reader.
// Segments are active-low, bit0=a .. bit6=g.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} scan_state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational inverse of the display driver's hex-to-glyph table.
// Patterns that are neither a glyph nor all-off report legal=0, blank=0.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] hex,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    hex   = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg_n)
      SEG_0:     hex = 4'h0;
      SEG_1:     hex = 4'h1;
      SEG_2:     hex = 4'h2;
      SEG_3:     hex = 4'h3;
      SEG_4:     hex = 4'h4;
      SEG_5:     hex = 4'h5;
      SEG_6:     hex = 4'h6;
      SEG_7:     hex = 4'h7;
      SEG_8:     hex = 4'h8;
      SEG_9:     hex = 4'h9;
      SEG_A:     hex = 4'hA;
      SEG_B:     hex = 4'hB;
      SEG_C:     hex = 4'hC;
      SEG_D:     hex = 4'hD;
      SEG_E:     hex = 4'hE;
      SEG_F:     hex = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low 7-seg bus and rebuilds the hex value per digit.
// Optional SEG_SCAN_CHANGE_EN adds a value_changed pulse aligned with output updates.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done,
  output logic                    anode_err
`ifdef SEG_SCAN_CHANGE_EN
  ,
  output logic                    value_changed
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0] an_m, s_an;
  logic [6:0]            seg_m, s_seg;
  logic [CW-1:0]         cnt_q;
  scan_state_t           state_q, state_d;
  logic                  strobe, one_hot, chg_in;
  logic [3:0]            hex;
  logic                  legal, blank;
  logic [NUM_DIGITS-1:0] seen_q, seen_nx;

  logic [NUM_DIGITS-1:0][3:0] dig_q;
  logic [NUM_DIGITS-1:0]      val_q, blk_q, err_q;

  // Synchronizers park at the idle pattern so reset never looks like a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m  <= '1;
      s_an  <= '1;
      seg_m <= SEG_BLANK;
      s_seg <= SEG_BLANK;
    end else begin
      an_m  <= an_n;
      s_an  <= an_m;
      seg_m <= seg_n;
      s_seg <= seg_m;
    end
  end

  // cnt_q moves with s_an/s_seg: it reads 1 on the first cycle of a new value.
  assign chg_in = {an_m, seg_m} != {s_an, s_seg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (chg_in)
      cnt_q <= CW'(1);
    else if (cnt_q != CW'(STABLE_CYCLES))
      cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) anode_err <= 1'b0;
    else        anode_err <= !$onehot0(~an_m) && $onehot0(~s_an);
  end

  assign one_hot = $onehot(~s_an);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    strobe  = 1'b0;
    case (state_q)
      IDLE: if (one_hot) state_d = SETTLE;
      SETTLE, CAPTURED: begin
        if (!one_hot)
          state_d = IDLE;
        else if (cnt_q == CW'(1))
          state_d = SETTLE;
        else if (state_q == SETTLE && cnt_q == CW'(STABLE_CYCLES)) begin
          strobe  = 1'b1;
          state_d = CAPTURED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  seg_to_hex u_dec (
    .seg_n (s_seg),
    .hex   (hex),
    .legal (legal),
    .blank (blank)
  );

`ifdef SEG_SCAN_CHANGE_EN
  logic [NUM_DIGITS-1:0] chg;
`endif

  // Per-digit result registers; a strobe targets the single low anode.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic       hit;
    logic [3:0] d_q;
    logic       v_q, b_q, e_q;

    assign hit = strobe && !s_an[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= 4'h0;
        v_q <= 1'b0;
        b_q <= 1'b0;
        e_q <= 1'b0;
      end else if (hit) begin
        if (legal) d_q <= hex;
        v_q <= legal;
        b_q <= blank;
        e_q <= !legal && !blank;
      end
    end

    assign dig_q[g] = d_q;
    assign val_q[g] = v_q;
    assign blk_q[g] = b_q;
    assign err_q[g] = e_q;
`ifdef SEG_SCAN_CHANGE_EN
    assign chg[g] = hit && ((legal && d_q != hex) || v_q != legal || b_q != blank);
`endif
  end

  assign digits      = dig_q;
  assign digit_valid = val_q;
  assign digit_blank = blk_q;
  assign digit_err   = err_q;

  // Strobe implies exactly one low anode, so ~s_an is the digit's seen bit.
  assign seen_nx = seen_q | ~s_an;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (strobe) begin
        if (&seen_nx) begin
          seen_q     <= '0;
          frame_done <= 1'b1;
        end else begin
          seen_q <= seen_nx;
        end
      end
    end
  end

`ifdef SEG_SCAN_CHANGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_changed <= 1'b0;
    else        value_changed <= |chg;
  end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] digits;
  logic [3:0]  digit_valid, digit_blank, digit_err;
  logic        frame_done, anode_err;
`ifdef SEG_SCAN_CHANGE_EN
  logic        value_changed;
`endif

  int ntest = 0;
  int nfail = 0;
  int fd_cnt, ae_cnt;

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
`ifdef SEG_SCAN_CHANGE_EN
    .value_changed (value_changed),
`endif
    .frame_done  (frame_done),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fd_cnt <= 0;
      ae_cnt <= 0;
    end else begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (anode_err)  ae_cnt <= ae_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pins(input logic [3:0] a, input logic [6:0] s);
    an_n  = a;
    seg_n = s;
  endtask

  logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_tab [4] = '{7'h79, 7'h08, 7'h03, 7'h0E};
  logic       saw3;

  initial begin
    rst_n = 1'b0;
    pins(4'($urandom), 7'($urandom));
    step(3);
    pins(4'hF, 7'h7F);
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid",  32'(digit_valid), 32'h0);
    chk("rst_blank",  32'(digit_blank), 32'h0);
    chk("rst_err",    32'(digit_err), 32'h0);
    chk("rst_pulses", 32'(fd_cnt + ae_cnt), 32'h0);

    // Single digit: update lands on the 6th edge after the pins change.
    pins(4'hE, 7'h30);
    step(5);
    chk("single_edge5", 32'(digits), 32'h0);
    step(1);
    chk("single_edge6", 32'(digits), 32'h0003);
    chk("single_valid", 32'(digit_valid), 32'h1);
    step(10);
    chk("single_hold", 32'(digits), 32'h0003);
    chk("single_nofd", 32'(fd_cnt), 32'h0);

    // Glitch: 30 for only 3 cycles on digit 1, then 24 held.
    pins(4'hF, 7'h7F);
    step(3);
    saw3 = 1'b0;
    pins(4'hD, 7'h30);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (digits[7:4] == 4'h3) saw3 = 1'b1;
    end
    pins(4'hD, 7'h24);
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (digits[7:4] == 4'h3) saw3 = 1'b1;
    end
    chk("glitch_no3",   32'(saw3), 32'h0);
    chk("glitch_value", 32'(digits), 32'h0023);

    // Full scan; digits 0 and 1 are already seen, so the pulse comes on digit 3.
    pins(4'hF, 7'h7F);
    step(3);
    for (int k = 0; k < 3; k++) begin
      pins(an_tab[k], seg_tab[k]);
      step(8);
    end
    chk("scan1_pre_fd", 32'(fd_cnt), 32'h0);
    pins(an_tab[3], seg_tab[3]);
    step(5);
    chk("scan1_fd_early", 32'(frame_done), 32'h0);
    step(1);
    chk("scan1_fd_edge", 32'(frame_done), 32'h1);
    step(2);
    chk("scan1_fd_cnt", 32'(fd_cnt), 32'h1);
    chk("scan1_digits", 32'(digits), 32'hFBA1);
    chk("scan1_valid",  32'(digit_valid), 32'hF);

    for (int k = 0; k < 4; k++) begin
      pins(an_tab[k], seg_tab[k]);
      step(8);
    end
    chk("scan2_fd_cnt", 32'(fd_cnt), 32'h2);
    chk("scan2_digits", 32'(digits), 32'hFBA1);

    // Blank on digit 1, illegal pattern on digit 2.
    pins(4'hD, 7'h7F);
    step(8);
    pins(4'hB, 7'h55);
    step(8);
    chk("bi_digits", 32'(digits), 32'hFBA1);
    chk("bi_valid",  32'(digit_valid), 32'h9);
    chk("bi_blank",  32'(digit_blank), 32'h2);
    chk("bi_err",    32'(digit_err), 32'h4);
    chk("bi_nofd",   32'(fd_cnt), 32'h2);

    // Two anodes low: one fault pulse, nothing captured.
    pins(4'hF, 7'h7F);
    step(3);
    pins(4'hC, 7'h30);
    step(10);
    chk("anode_err_cnt", 32'(ae_cnt), 32'h1);
    chk("anode_digits",  32'(digits), 32'hFBA1);
    chk("anode_valid",   32'(digit_valid), 32'h9);
    pins(4'hE, 7'h30);
    step(8);
    chk("resume_digits", 32'(digits), 32'hFBA3);
    chk("resume_nofd",   32'(fd_cnt), 32'h2);
    pins(4'h7, 7'h40);
    step(8);
    chk("resume_d3",     32'(digits), 32'h0BA3);
    chk("resume_fd",     32'(fd_cnt), 32'h3);
    chk("resume_ae",     32'(ae_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reader for the multiplexed seven-segment display bus of the vending machine: samples active-low anode and segment lines and reconstructs the hex value shown on each digit.
- Used by the self-test / display-monitor path to confirm what the display is actually showing.
- The inverse of the hex-to-segment glyph encoding used by the display driver.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits / anode lines (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- an_n  in  NUM_DIGITS  anode enables, active-low, asynchronous to clk
- seg_n  in  7  segments, active-low, bit0=a .. bit6=g, asynchronous to clk
- digits  out  4*NUM_DIGITS  decoded hex per digit, digit i in bits [4i+3:4i]
- digit_valid  out  NUM_DIGITS  last capture of digit i was a legal glyph
- digit_blank  out  NUM_DIGITS  last capture of digit i was all segments off
- digit_err  out  NUM_DIGITS  last capture of digit i was an illegal pattern
- frame_done  out  1  1-cycle pulse when every digit has been captured since the previous pulse
- anode_err  out  1  1-cycle pulse on entry into a multi-hot anode condition

Behaviour:
- Reset is async on rst_n low. All outputs go to 0, FSM goes to IDLE, the seen-mask and counter are cleared. Reset mid-capture discards the pending capture.
- Input synchronization:
  - an_n and seg_n each pass through a 2-flop synchronizer, giving s_an and s_seg.
  - Detection logic uses only the synchronized values.
- Stability counter:
  - cnt = number of consecutive cycles {s_an, s_seg} has held its current value. It is 1 on the first cycle of a new value and saturates at STABLE_CYCLES.
- FSM:
  - IDLE: s_an has zero or more than one bit low. Go to SETTLE when exactly one bit is low.
  - SETTLE: exactly one anode low. Go to CAPTURED when cnt reaches STABLE_CYCLES; a capture strobe fires on that cycle. Any change in {s_an, s_seg} returns to SETTLE (cnt=1) if still one-hot, else IDLE.
  - CAPTURED: hold with no further strobes until {s_an, s_seg} changes, then same exit rules as SETTLE.
- anode_err pulses for one cycle on the cycle s_an first becomes multi-hot, from any state.
- Capture timing: outputs update on the edge after the strobe. A pin change that then holds is reflected STABLE_CYCLES+2 edges after the first edge that samples it.
- Capture action, for index i = position of the low anode:
  - Legal glyph: digits[i] gets the hex value; valid=1, blank=0, err=0.
  - seg_n=7F: valid=0, blank=1, err=0; digits[i] unchanged.
  - Any other pattern: valid=0, blank=0, err=1; digits[i] unchanged.
- Legal glyphs, seg_n hex:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- frame_done:
  - Every strobe sets seen[i], whatever the pattern class.
  - When seen, including the current strobe, is all-ones, frame_done pulses on the output-update edge and seen clears.
  - Re-capturing an already-seen digit does not pulse.
- Other digits' outputs hold between captures.

Optional Feature:
- Macro SEG_SCAN_CHANGE_EN.
- When defined: adds output port value_changed (1 bit). It pulses for one cycle, aligned with the output update, when a capture changes digits[i], or digit_valid[i], or digit_blank[i].
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package seg_pkg:
  - Glyph constants SEG_0..SEG_F and SEG_BLANK=7'h7F.
  - Enum scan_state_t {IDLE, SETTLE, CAPTURED}.
- Sub-module seg_to_hex, combinational:
  - Inputs: seg_n[6:0].
  - Outputs: hex[3:0], legal, blank.
  - Must be the exact inverse of the driver's encoding table.

Test Plan:
- Reset: hold rst_n=0 with random pins, release -> all outputs 0, no pulses for STABLE_CYCLES+2 cycles after pins go idle (an_n=F).
- Single digit: an_n=E, seg_n=30 held -> on edge 6 digits[3:0]=3, digit_valid=0001. Exactly one capture; no repeat while held.
- Full scan: cycle an_n E,D,B,7 with seg_n 79,08,03,0E, each held 8 cycles -> digits=F_b_A_1 (16'hFBA1). frame_done pulses once, on the digit-3 update. A second full scan pulses again.
- Glitch rejection: an_n=E with seg_n=30 for 3 cycles, then 24 held -> only value 2 is captured; the 3-cycle 30 never appears.
- Blank/illegal: digit 1 gets 7F -> digit_blank[1]=1, valid[1]=0, digits[7:4] held. Digit 2 gets 55 -> digit_err[2]=1, digits[11:8] held.
- Anode fault: an_n=C -> anode_err pulses once, FSM in IDLE, no capture. Return to an_n=E -> normal capture resumes.
